// File: rtl/prog_freq_div.sv
// Run-time programmable frequency divider: 50% duty square wave OUT plus a TICK strobe per edge.
// Half-period changes only at a wrap, and disabling always finishes the current full period.
module prog_freq_div #(
    parameter int unsigned WIDTH        = 20,
    parameter int unsigned DEFAULT_HALF = 524287
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] HALF_IN,
    output logic             OUT,
    output logic             TICK,
    output logic             RUNNING,
    output logic [WIDTH-1:0] COUNT
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign wrap = (state_q != StIdle) && (count_q == half_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        half_d    = half_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        out_d     = out_q;
        tick_d    = 1'b0;

        if (state_q == StIdle) begin
            count_d = '0;
            out_d   = 1'b0;
            if (LOAD) begin
                half_d = HALF_IN;
            end
            if (ENABLE) begin
                state_d = StRun;
            end
        end else begin
            if (wrap) begin
                count_d = '0;
                out_d   = ~out_q;
                tick_d  = 1'b1;
                // A load landing on the wrap itself bypasses the shadow register.
                if (LOAD) begin
                    half_d    = HALF_IN;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    half_d    = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
                if (LOAD) begin
                    shadow_d  = HALF_IN;
                    pending_d = 1'b1;
                end
            end

            unique case (state_q)
                StRun: begin
                    if (!ENABLE) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (ENABLE) begin
                        state_d = StRun;
                    end else if (wrap && out_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= StIdle;
            count_q   <= '0;
            half_q    <= WIDTH'(DEFAULT_HALF);
            shadow_q  <= '0;
            pending_q <= 1'b0;
            out_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            half_q    <= half_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
        end
    end

    assign OUT     = out_q;
    assign TICK    = tick_q;
    assign COUNT   = count_q;
    assign RUNNING = (state_q != StIdle);

endmodule

// File: tb/tb_prog_freq_div.sv
// Directed bench for prog_freq_div at WIDTH=8, DEFAULT_HALF=3.
module tb_prog_freq_div;

    localparam int unsigned W = 8;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b0;
    logic         ENABLE = 1'b0;
    logic         LOAD = 1'b0;
    logic [W-1:0] HALF_IN = '0;
    logic         OUT;
    logic         TICK;
    logic         RUNNING;
    logic [W-1:0] COUNT;

    int n_vec = 0;
    int n_err = 0;

    prog_freq_div #(
        .WIDTH        (W),
        .DEFAULT_HALF (3)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .LOAD    (LOAD),
        .HALF_IN (HALF_IN),
        .OUT     (OUT),
        .TICK    (TICK),
        .RUNNING (RUNNING),
        .COUNT   (COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    // Advance one rising edge; outputs are then stable for sampling and inputs may change.
    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    // Expected waveform k cycles after RUN entry with half-period h (k=0 is the entry edge).
    function automatic logic e_out(int k, int h);
        return logic'((k / (h + 1)) % 2);
    endfunction
    function automatic logic [W-1:0] e_cnt(int k, int h);
        return W'(k % (h + 1));
    endfunction
    function automatic logic e_tick(int k, int h);
        return (k >= h + 1) && (k % (h + 1) == 0);
    endfunction

    task automatic do_reset();
        RESET = 1'b1; ENABLE = 1'b0; LOAD = 1'b0; HALF_IN = '0;
        cyc();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b1; LOAD = 1'b0;
        cyc();
        RESET = 1'b0; ENABLE = 1'b0;
        n_vec++;
        if ({OUT, TICK, RUNNING, COUNT} !== {3'b000, 8'd0}) begin
            n_err++;
            $display("FAIL reset: out/tick/run/count got %b%b%b/%0d want 000/0", OUT, TICK, RUNNING,
                     COUNT);
        end
        cyc();
        n_vec++;
        if ({OUT, RUNNING, COUNT} !== {2'b00, 8'd0}) begin
            n_err++;
            $display("FAIL idle_hold: out/run/count got %b%b/%0d want 00/0", OUT, RUNNING, COUNT);
        end
    endtask

    task automatic test_run();
        do_reset();
        ENABLE = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc();
            n_vec++;
            if (OUT !== e_out(k, 3) || TICK !== e_tick(k, 3) || COUNT !== e_cnt(k, 3)
                || RUNNING !== 1'b1) begin
                n_err++;
                $display("FAIL run k=%0d: out/tick/cnt/run got %b/%b/%0d/%b want %b/%b/%0d/1", k, OUT,
                         TICK, COUNT, RUNNING, e_out(k, 3), e_tick(k, 3), e_cnt(k, 3));
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        ENABLE = 1'b1;
        for (int k = 0; k <= 9; k++) cyc();
        // Now OUT=0, count=1.
        ENABLE = 1'b0;
        for (int k = 10; k <= 15; k++) begin
            cyc();
            n_vec++;
            if (OUT !== e_out(k, 3) || TICK !== e_tick(k, 3) || RUNNING !== 1'b1) begin
                n_err++;
                $display("FAIL drain k=%0d: out/tick/run got %b/%b/%b want %b/%b/1", k, OUT, TICK,
                         RUNNING, e_out(k, 3), e_tick(k, 3));
            end
        end
        cyc();
        n_vec++;
        if ({OUT, TICK, RUNNING, COUNT} !== {3'b010, 8'd0}) begin
            n_err++;
            $display("FAIL drain_end: out/tick/run/count got %b%b%b/%0d want 010/0", OUT, TICK,
                     RUNNING, COUNT);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if ({OUT, TICK, RUNNING, COUNT} !== {3'b000, 8'd0}) begin
                n_err++;
                $display("FAIL drain_idle %0d: out/tick/run/count got %b%b%b/%0d want 000/0", i, OUT,
                         TICK, RUNNING, COUNT);
            end
        end
    endtask

    task automatic test_reenable();
        do_reset();
        ENABLE = 1'b1;
        for (int k = 0; k <= 12; k++) cyc();
        ENABLE = 1'b0;
        for (int k = 13; k <= 31; k++) begin
            if (k == 15) ENABLE = 1'b1;
            cyc();
            n_vec++;
            if (OUT !== e_out(k, 3) || TICK !== e_tick(k, 3) || COUNT !== e_cnt(k, 3)
                || RUNNING !== 1'b1) begin
                n_err++;
                $display("FAIL reenable k=%0d: out/tick/cnt/run got %b/%b/%0d/%b want %b/%b/%0d/1", k,
                         OUT, TICK, COUNT, RUNNING, e_out(k, 3), e_tick(k, 3), e_cnt(k, 3));
            end
        end
    endtask

    task automatic test_load_midhalf();
        do_reset();
        ENABLE = 1'b1;
        for (int k = 0; k <= 5; k++) cyc();
        LOAD = 1'b1; HALF_IN = 8'd1;
        for (int k = 6; k <= 20; k++) begin
            logic eo;
            logic et;
            logic [W-1:0] ec;
            cyc();
            LOAD = 1'b0;
            if (k < 8) begin
                eo = e_out(k, 3); et = e_tick(k, 3); ec = e_cnt(k, 3);
            end else begin
                eo = logic'(((k - 8) / 2) % 2); et = ((k - 8) % 2 == 0); ec = W'((k - 8) % 2);
            end
            n_vec++;
            if (OUT !== eo || TICK !== et || COUNT !== ec) begin
                n_err++;
                $display("FAIL load_mid k=%0d: out/tick/cnt got %b/%b/%0d want %b/%b/%0d", k, OUT,
                         TICK, COUNT, eo, et, ec);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        do_reset();
        ENABLE = 1'b1;
        for (int k = 0; k <= 3; k++) cyc();
        LOAD = 1'b1; HALF_IN = 8'd1;
        for (int k = 4; k <= 16; k++) begin
            logic eo;
            cyc();
            LOAD = 1'b0;
            eo = (((k - 4) / 2) % 2 == 0);
            n_vec++;
            if (OUT !== eo || TICK !== ((k - 4) % 2 == 0) || COUNT !== W'((k - 4) % 2)) begin
                n_err++;
                $display("FAIL load_wrap k=%0d: out/tick/cnt got %b/%b/%0d want %b/%b/%0d", k, OUT,
                         TICK, COUNT, eo, ((k - 4) % 2 == 0), (k - 4) % 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ENABLE = 1'b1;
        for (int k = 0; k <= 1; k++) cyc();
        LOAD = 1'b1; HALF_IN = 8'd5;
        cyc();
        HALF_IN = 8'd0;
        cyc();
        LOAD = 1'b0;
        for (int k = 4; k <= 14; k++) begin
            cyc();
            n_vec++;
            if (OUT !== ((k - 4) % 2 == 0) || TICK !== 1'b1 || COUNT !== 8'd0) begin
                n_err++;
                $display("FAIL h0 k=%0d: out/tick/cnt got %b/%b/%0d want %b/1/0", k, OUT, TICK, COUNT,
                         ((k - 4) % 2 == 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ENABLE = 1'b1; LOAD = 1'b1; HALF_IN = 8'd1;
        cyc();
        LOAD = 1'b0;
        for (int k = 1; k <= 3; k++) cyc();
        n_vec++;
        if (OUT !== 1'b1 || COUNT !== 8'd1) begin
            n_err++;
            $display("FAIL load_enable_idle: out/cnt got %b/%0d want 1/1", OUT, COUNT);
        end
        RESET = 1'b1; LOAD = 1'b1; HALF_IN = 8'd7;
        cyc();
        RESET = 1'b0; LOAD = 1'b0;
        n_vec++;
        if ({OUT, TICK, RUNNING, COUNT} !== {3'b000, 8'd0}) begin
            n_err++;
            $display("FAIL reset_mid: out/tick/run/count got %b%b%b/%0d want 000/0", OUT, TICK,
                     RUNNING, COUNT);
        end
        for (int k = 0; k <= 12; k++) begin
            cyc();
            n_vec++;
            if (OUT !== e_out(k, 3) || TICK !== e_tick(k, 3) || COUNT !== e_cnt(k, 3)) begin
                n_err++;
                $display("FAIL reset_h k=%0d: out/tick/cnt got %b/%b/%0d want %b/%b/%0d", k, OUT, TICK,
                         COUNT, e_out(k, 3), e_tick(k, 3), e_cnt(k, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_drain();
        test_reenable();
        test_load_midhalf();
        test_load_on_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
